// File: rtl/sample_fifo_param.sv
// Single-port command FIFO for capture samples: one read or write per clock,
// registered status, sticky error flags and an optional overwrite-oldest mode.
module sample_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32768,
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       rnw,
    input  logic                       clear,
    input  logic                       circular,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    output logic                       wrapped
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_next;
    logic                  do_write;
    logic                  do_read;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  overwrite;

    // Command: en qualifies the cycle, rnw picks read (1) or write (0);
    // reset and clear both suppress the command in the same cycle.
    always_comb begin
        do_write   = en & ~rnw & ~clear & ~reset;
        do_read    = en &  rnw & ~clear & ~reset;
        wr_accept  = do_write & (~full | circular);
        overwrite  = do_write & full & circular;
        rd_accept  = do_read & ~empty;
        count_next = count;
        if (wr_accept && !overwrite) begin
            count_next = count + CW'(1);
        end else if (rd_accept) begin
            count_next = count - CW'(1);
        end
    end

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            wrapped      <= 1'b0;
            data_out     <= '0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            wrapped      <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            // An overwrite discards the oldest entry, so the read side advances too.
            if (rd_accept || overwrite) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (rd_accept) begin
                data_out <= mem[rd_ptr];
            end
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
            overflow     <= overflow  | (do_write & full & ~circular);
            underflow    <= underflow | (do_read & empty);
            wrapped      <= wrapped   | overwrite;
        end
    end

endmodule
